// File: rtl/mem_arb_pkg.sv
// Shared FSM states, grant encoding and latency limits for mem_port_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_e;

  typedef enum logic {GNT_IF, GNT_D} grant_e;

  localparam int MEM_LATENCY_MAX = 4;
  // The counter only ever holds MEM_LATENCY-1, so MAX-1 must fit.
  localparam int LAT_CNT_W = $clog2(MEM_LATENCY_MAX);

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the fetch port and the load/store port, one transaction at a time.
// Optional: define MEM_ARB_ROUND_ROBIN_EN to alternate ties between ports instead of data-first priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   m_addr,
  output logic                m_re,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be within 1..%0d", MEM_LATENCY_MAX);
  end

  arb_state_e           state, next_state;
  grant_e               grant, pick;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic [ADDR_W-1:0]    lat_addr;
  logic                 lat_we;
  logic [DATA_W/8-1:0]  lat_wstrb;
  logic [DATA_W-1:0]    lat_wdata;
  logic                 any_req;

  assign any_req = if_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  grant_e last_grant;

  always_comb begin
    if (if_req && d_req) pick = (last_grant == GNT_D) ? GNT_IF : GNT_D;
    else if (d_req)      pick = GNT_D;
    else                 pick = GNT_IF;
  end

  // Reset value "data" makes the very first tie go to fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          last_grant <= GNT_D;
    else if (state == IDLE && any_req) last_grant <= pick;
  end
`else
  assign pick = d_req ? GNT_D : GNT_IF;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  next_state = lat_we ? RESP : WAIT;
      WAIT:    if (lat_cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The winning port's fields are frozen at grant, so a requester dropping req mid-flight is harmless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant     <= GNT_D;
      lat_cnt   <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wstrb <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick;
            if (pick == GNT_D) begin
              lat_addr  <= d_addr;
              lat_we    <= d_we;
              lat_wstrb <= d_we ? d_wstrb : '0;
              lat_wdata <= d_we ? d_wdata : '0;
            end else begin
              lat_addr  <= if_addr;
              lat_we    <= 1'b0;
              lat_wstrb <= '0;
              lat_wdata <= '0;
            end
          end
        end
        ACCESS: lat_cnt <= LAT_CNT_W'(MEM_LATENCY - 1);
        WAIT: begin
          if (lat_cnt == '0) begin
            if (grant == GNT_D) d_rdata  <= m_rdata;
            else                if_rdata <= m_rdata;
          end else begin
            lat_cnt <= lat_cnt - LAT_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // RAM-side fields come straight from grant-time registers and are forced to zero outside ACCESS.
  assign busy    = (state != IDLE);
  assign m_re    = (state == ACCESS) && !lat_we;
  assign m_we    = (state == ACCESS) && lat_we;
  assign m_addr  = (state == ACCESS) ? lat_addr  : '0;
  assign m_wstrb = (state == ACCESS) ? lat_wstrb : '0;
  assign m_wdata = (state == ACCESS) ? lat_wdata : '0;
  assign if_ack  = (state == RESP) && (grant == GNT_IF);
  assign d_ack   = (state == RESP) && (grant == GNT_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a latency-accurate RAM model and a word-level reference memory.
// Honours MEM_ARB_ROUND_ROBIN_EN when predicting the grant order under contention.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic        clk, rst;
  logic        if_req, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_re, m_we, busy;
  logic [3:0]  m_wstrb;

  int total, bad;
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_fetch;
  int          want[$];
  int          got_q[$];
  bit          cur_d_we;
  logic [31:0] cur_d_addr, cur_d_wdata, cur_if_addr;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data is valid only in the LAT-th cycle after the strobe cycle, junk otherwise.
  logic [31:0] ram [0:255];
  logic        rd_vld [1:LAT];
  logic [7:0]  rd_idx [1:LAT];

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    rd_vld[1] <= m_re;
    rd_idx[1] <= m_addr[9:2];
    for (int k = 2; k <= LAT; k++) begin
      rd_vld[k] <= rd_vld[k-1];
      rd_idx[k] <= rd_idx[k-1];
    end
    if (m_we) ram[m_addr[9:2]] <= merge_word(ram[m_addr[9:2]], m_wdata, m_wstrb);
  end

  assign m_rdata = rd_vld[LAT] ? ram[rd_idx[LAT]] : 32'hBAD0_BAD0;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference memory: byte-enable merge done with masks on whole words.
  task automatic ref_store(input logic [31:0] a, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] mask = '0;
    logic [31:0] old  = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8*b));
    ref_mem[a] = (old & ~mask) | (data & mask);
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic apply_stimulus(input bit use_d, input bit we, input logic [3:0] strb,
                                input logic [31:0] a, input logic [31:0] wd);
    if (use_d) begin
      d_req = 1'b1; d_we = we; d_wstrb = strb; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
  endtask

  // Cycle 0 is the IDLE cycle that sees req; ack is due in cycle 2 (store) or LAT+2 (load).
  task automatic wait_ack(input bit use_d, input bit we, input logic [31:0] a, input logic [3:0] strb,
                          input logic [31:0] wd, input int start_cyc, input string tag);
    int cyc = start_cyc;
    bit got = 1'b0;
    logic [31:0] exp_rd;
    while (!got && cyc < 30) begin
      step();
      cyc++;
      if (cyc == 1) begin
        check_output({tag, ".m_re"}, m_re, !we);
        check_output({tag, ".m_we"}, m_we, we);
        check_output({tag, ".m_addr"}, m_addr, a);
        check_output({tag, ".m_wstrb"}, m_wstrb, we ? strb : 4'h0);
        check_output({tag, ".m_wdata"}, m_wdata, we ? wd : 32'h0);
        check_output({tag, ".busy"}, busy, 1);
      end
      check_output({tag, ".ack_overlap"}, if_ack & d_ack, 0);
      got = use_d ? d_ack : if_ack;
    end
    check_output({tag, ".ack_cycle"}, cyc, we ? 2 : LAT + 2);
    if (!we) begin
      exp_rd = ref_load(a);
      check_output({tag, ".rdata"}, use_d ? d_rdata : if_rdata, exp_rd);
      if (!use_d) last_fetch = exp_rd;
    end
    if (use_d) d_req = 1'b0; else if_req = 1'b0;
    step();
    check_output({tag, ".ack_pulse"}, use_d ? d_ack : if_ack, 0);
    check_output({tag, ".busy_after"}, busy, 0);
  endtask

  task automatic full_txn(input bit use_d, input bit we, input logic [3:0] strb,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
    if (we) ref_store(a, wd, strb);
    apply_stimulus(use_d, we, strb, a, wd);
    wait_ack(use_d, we, a, strb, wd, 0, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, ".m_re"}, m_re, 0);
    check_output({tag, ".m_we"}, m_we, 0);
    check_output({tag, ".m_addr"}, m_addr, 0);
    check_output({tag, ".m_wstrb"}, m_wstrb, 0);
    check_output({tag, ".m_wdata"}, m_wdata, 0);
    check_output({tag, ".busy"}, busy, 0);
    check_output({tag, ".if_ack"}, if_ack, 0);
    check_output({tag, ".d_ack"}, d_ack, 0);
    check_output({tag, ".if_rdata"}, if_rdata, 0);
    check_output({tag, ".d_rdata"}, d_rdata, 0);
  endtask

  task automatic issue_d(input int k);
    cur_d_we    = (k % 2 == 0);
    cur_d_addr  = cur_d_we ? 32'h300 + 32'(4 * k) : 32'h300 + 32'(4 * (k - 1));
    cur_d_wdata = $urandom;
    apply_stimulus(1'b1, cur_d_we, 4'hF, cur_d_addr, cur_d_wdata);
  endtask

  task automatic issue_if(input int k);
    cur_if_addr = 32'h200 + 32'(4 * (k % 12));
    apply_stimulus(1'b0, 1'b0, 4'h0, cur_if_addr, 32'h0);
  endtask

  int          n_if, n_d, cyc;
  bit          last_d, pick_d, rnd_d;
  logic [3:0]  rnd_strb;
  logic [31:0] a;

  initial begin
    total = 0; bad = 0; last_fetch = '0;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    step(); step(); step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    $display("[TB] fetch-only");
    full_txn(1, 1, 4'hF, 32'h10, 32'h0010_0093, "prep_store");
    full_txn(0, 0, 4'h0, 32'h10, 32'h0, "fetch");
    check_output("fetch.const", if_rdata, 32'h0010_0093);

    $display("[TB] store then byte store then load");
    full_txn(1, 1, 4'hF, 32'h100, 32'hDEAD_BEEF, "store_full");
    full_txn(1, 1, 4'h1, 32'h100, 32'h0000_0055, "store_byte");
    full_txn(1, 0, 4'h0, 32'h100, 32'h0, "load_merged");
    check_output("load_merged.const", d_rdata, 32'hDEAD_BE55);
    full_txn(1, 1, 4'h0, 32'h100, 32'hFFFF_FFFF, "store_nostrb");
    full_txn(1, 0, 4'h0, 32'h100, 32'h0, "load_after_nostrb");
    check_output("load_after_nostrb.const", d_rdata, 32'hDEAD_BE55);
    check_output("if_rdata_hold", if_rdata, 32'h0010_0093);

    $display("[TB] randomized stores and loads");
    for (int i = 0; i < 12; i++) full_txn(1, 1, 4'hF, 32'h200 + 32'(4 * i), $urandom, "rnd_fill");
    for (int i = 0; i < 8; i++) begin
      a = 32'h200 + 32'(4 * $urandom_range(0, 11));
      rnd_strb = 4'($urandom_range(0, 15));
      full_txn(1, 1, rnd_strb, a, $urandom, "rnd_part");
    end
    for (int i = 0; i < 12; i++) begin
      a = 32'h200 + 32'(4 * $urandom_range(0, 11));
      rnd_d = 1'($urandom_range(0, 1));
      full_txn(rnd_d, 0, 4'h0, a, 32'h0, "rnd_load");
    end

    $display("[TB] contention, four transactions per port");
    n_if = 4; n_d = 4; last_d = 1'b1;
    while (n_if + n_d > 0) begin
      if (n_if > 0 && n_d > 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_d = !last_d;
`else
        pick_d = 1'b1;
`endif
      end else begin
        pick_d = (n_d > 0);
      end
      want.push_back(int'(pick_d));
      if (pick_d) n_d--; else n_if--;
      last_d = pick_d;
    end
    n_if = 0; n_d = 0; cyc = 0;
    issue_if(0);
    issue_d(0);
    while (got_q.size() < 8 && cyc < 300) begin
      step();
      cyc++;
      check_output("cont.ack_overlap", if_ack & d_ack, 0);
      if (d_ack) begin
        got_q.push_back(1);
        if (cur_d_we) ref_store(cur_d_addr, cur_d_wdata, 4'hF);
        else check_output("cont.d_rdata", d_rdata, ref_load(cur_d_addr));
        n_d++;
        if (n_d < 4) issue_d(n_d); else d_req = 1'b0;
      end
      if (if_ack) begin
        got_q.push_back(0);
        check_output("cont.if_rdata", if_rdata, ref_load(cur_if_addr));
        n_if++;
        if (n_if < 4) issue_if(n_if); else if_req = 1'b0;
      end
    end
    check_output("cont.count", got_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got_q.size()) check_output($sformatf("cont.grant%0d", i), got_q[i], want[i]);
    step();
    check_output("cont.busy_after", busy, 0);

    $display("[TB] request dropped during WAIT");
    a = 32'h204;
    apply_stimulus(1, 0, 4'h0, a, 32'h0);
    step(); step();
    d_req = 1'b0;
    wait_ack(1, 0, a, 4'h0, 32'h0, 2, "drop");
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("drop.no_second_ack", d_ack, 0);
      check_output("drop.idle", busy, 0);
    end

    $display("[TB] reset during a load");
    apply_stimulus(1, 0, 4'h0, 32'h100, 32'h0);
    step(); step();
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    step(); step();
    check_output("rst_hold.busy", busy, 0);
    check_output("rst_hold.d_ack", d_ack, 0);
    rst = 1'b1;
    wait_ack(1, 0, 32'h100, 4'h0, 32'h0, 0, "rst_reserve");
    check_output("rst_reserve.const", d_rdata, 32'hDEAD_BE55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
